// File: rtl/serial_frame_loader.sv
// Serial-to-parallel frame loader: MSB-first data bits plus one parity bit.
// A good frame updates Dout and pulses load_en; a bad one pulses parity_err.
module serial_frame_loader #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] Dout,
    output logic             load_en,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             good;
    logic             frame_good;

    // Parity over the assembled data bits and the bit on sin this cycle.
    assign frame_good = (((^shreg) ^ sin) == PARITY_ODD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = PARITY;
            PARITY:  state_nxt = RESULT;
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            shreg <= '0;
            good  <= 1'b0;
            Dout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) cnt <= '0;
                end
                SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], sin};
                    cnt   <= cnt + 1'b1;
                end
                PARITY: begin
                    good <= frame_good;
                    if (frame_good) Dout <= shreg;
                end
                default: ;
            endcase
        end
    end

    // Pulses are decoded from the registered state and verdict, so they
    // vanish together with the state on an asynchronous reset.
    assign busy       = (state != IDLE);
    assign load_en    = (state == RESULT) && good;
    assign parity_err = (state == RESULT) && !good;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed and random frames into an odd-parity and an even-parity loader,
// checked against a frame-level parity/word model.
module tb_serial_frame_loader;

    logic       CLK;
    logic       RST;
    logic       start_o, sin_o, start_e, sin_e;
    logic [7:0] dout_o, dout_e;
    logic       le_o, le_e, busy_o, busy_e, pe_o, pe_e;

    int         n_cmp;
    int         n_fail;
    int         cyc;
    logic [7:0] exp_dout [2];
    int         last_load [2];
    int         load_gap;

    serial_frame_loader #(.WIDTH(8), .PARITY_ODD(1'b1)) dut_odd (
        .CLK(CLK), .RST(RST), .start(start_o), .sin(sin_o),
        .Dout(dout_o), .load_en(le_o), .busy(busy_o), .parity_err(pe_o)
    );

    serial_frame_loader #(.WIDTH(8), .PARITY_ODD(1'b0)) dut_even (
        .CLK(CLK), .RST(RST), .start(start_e), .sin(sin_e),
        .Dout(dout_e), .load_en(le_e), .busy(busy_e), .parity_err(pe_e)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic s);
        if (sel) begin
            start_e = st;
            sin_e   = s;
        end else begin
            start_o = st;
            sin_o   = s;
        end
    endtask

    task automatic check_outs(input bit sel, input string tag,
                              input logic eb, input logic ele, input logic epe);
        string p;
        p = $sformatf("%s_%s", sel ? "even" : "odd", tag);
        check({p, "_busy"},    sel ? busy_e : busy_o, eb);
        check({p, "_load_en"}, sel ? le_e : le_o, ele);
        check({p, "_par_err"}, sel ? pe_e : pe_o, epe);
        check({p, "_dout"},    sel ? dout_e : dout_o, exp_dout[sel]);
    endtask

    task automatic idle_cycles(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b0, 1'($urandom_range(0, 1)));
            tick();
            check_outs(sel, "idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One complete frame starting at E0; returns at the negedge after E10.
    task automatic run_frame(input bit sel, input logic [7:0] data, input logic par,
                             input bit extra_start);
        logic good;
        drive(sel, 1'b1, 1'($urandom_range(0, 1)));
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(sel, extra_start && (k == 2), data[7-k]);
            tick();
            check_outs(sel, "shift", 1'b1, 1'b0, 1'b0);
        end
        drive(sel, extra_start, par);
        tick();
        good = ((($countones(data) + int'(par)) % 2) == (sel ? 0 : 1));
        if (good) begin
            exp_dout[sel]  = data;
            load_gap       = cyc - last_load[sel];
            last_load[sel] = cyc;
        end
        check_outs(sel, "result", 1'b1, good, !good);
        drive(sel, 1'b0, 1'($urandom_range(0, 1)));
        tick();
        check_outs(sel, "after", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        load_gap     = 0;
        exp_dout[0]  = 8'h00;
        exp_dout[1]  = 8'h00;
        last_load[0] = 0;
        last_load[1] = 0;
        RST     = 1'b1;
        start_o = 1'b0;
        sin_o   = 1'b0;
        start_e = 1'b0;
        sin_e   = 1'b0;

        // Reset held with random inputs
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            check_outs(1'b0, "reset", 1'b0, 1'b0, 1'b0);
            check_outs(1'b1, "reset", 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        idle_cycles(1'b0, 2);

        // Good frame, bad parity, ignored start pulses
        run_frame(1'b0, 8'hAF, 1'b1, 1'b0);
        check("odd_dout_af", dout_o, 8'hAF);
        run_frame(1'b0, 8'hFA, 1'b0, 1'b0);
        check("odd_dout_keep_af", dout_o, 8'hAF);
        run_frame(1'b0, 8'h83, 1'b0, 1'b1);
        check("odd_dout_83", dout_o, 8'h83);
        idle_cycles(1'b0, 3);

        // Reset between E4 and E5
        drive(1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            tick();
        end
        check("odd_busy_before_abort", busy_o, 1'b1);
        RST = 1'b1;
        #1;
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        check_outs(1'b0, "abort", 1'b0, 1'b0, 1'b0);
        tick();
        check_outs(1'b0, "abort_hold", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        idle_cycles(1'b0, 3);
        run_frame(1'b0, 8'hF5, 1'b1, 1'b0);
        check("odd_dout_f5", dout_o, 8'hF5);

        // Back-to-back on the even-parity instance
        idle_cycles(1'b1, 2);
        run_frame(1'b1, 8'h01, 1'b1, 1'b0);
        check("even_dout_01", dout_e, 8'h01);
        run_frame(1'b1, 8'h00, 1'b0, 1'b0);
        check("even_dout_00", dout_e, 8'h00);
        check("even_load_gap", load_gap, 11);

        // Random frames with random idle gaps
        for (int i = 0; i < 16; i++) begin
            bit         sel;
            logic [7:0] data;
            logic       par;
            sel  = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            run_frame(sel, data, par, 1'($urandom_range(0, 1)));
            idle_cycles(sel, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_loader.md
# serial_frame_loader

Serial-to-parallel front end for the 8-bit load-enabled register stage. It receives a framed serial stream of WIDTH data bits, MSB first, followed by one parity bit. It checks the parity and, on a good frame, presents the assembled word on `Dout` with a one-cycle `load_en` pulse. Its outputs connect directly to the downstream register's `D` and `en` inputs, with `CLK`/`RST` shared.

## Interface
- `WIDTH`, 8 — data bits per frame; also the width of `Dout`.
- `PARITY_ODD`, 1 — 1: odd parity over data+parity bit; 0: even parity.

- `CLK`  input  1  — system clock; all state changes on its rising edge.
- `RST`  input  1  — asynchronous, active-high reset.
- `start`  input  1  — frame request; accepted only in IDLE.
- `sin`  input  1  — serial data/parity bit, sampled once per cycle in SHIFT/PARITY.
- `Dout`  output  WIDTH  — last good frame's word; drives downstream `D`.
- `load_en`  output  1  — one-cycle pulse: `Dout` holds a new good word; drives downstream `en`.
- `busy`  output  1  — high in every state except IDLE.
- `parity_err`  output  1  — one-cycle pulse: the frame just received failed parity.

## Operation
- States: IDLE, SHIFT, PARITY, RESULT. All outputs are registered or decoded from the registered state.
- IDLE: `busy`=0. If `start`=1 at an edge, clear the bit counter and go to SHIFT.
- SHIFT: each edge samples `sin` into the shift register, shifting left so the first bit lands in MSB. The counter increments from 0 to WIDTH-1. On the edge that samples bit WIDTH-1, go to PARITY.
- PARITY: at the edge, sample `sin` as the parity bit.
  - With `PARITY_ODD`=1, the frame is good when the XOR of the WIDTH data bits and the parity bit is 1. With `PARITY_ODD`=0, it is good when that XOR is 0.
  - Good frame: copy the shift register into `Dout` at this same edge.
  - Bad frame: `Dout` is unchanged.
  - Go to RESULT.
- RESULT (one cycle): `load_en`=1 if good, else `parity_err`=1. Never both. Unconditionally return to IDLE at the next edge.
- `start` outside IDLE is ignored and never queued. `sin` in IDLE/RESULT is ignored.
- Reset values: state IDLE, `Dout`=0, `load_en`=0, `parity_err`=0, `busy`=0, counter 0, shift register 0.
- `RST` asserted mid-frame aborts the frame immediately:
  - no `load_en` or `parity_err` pulse for that frame;
  - `Dout` is forced to 0;
  - after `RST` falls, the block waits in IDLE for a new `start`.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE.
- Data bit k (k=0 is the MSB) is sampled at edge E(1+k). Drive bit k on `sin` in the cycle before that edge.
- The parity bit is sampled at E(WIDTH+1), which is E9 for the default.
- `Dout` updates at E9. `load_en`/`parity_err` are high for the cycle E9–E10, so the downstream register captures `Dout` at E10.
- State is IDLE after E10. The earliest next `start` is sampled at E11, giving a minimum frame period of WIDTH+3 = 11 cycles.
- `busy` is high from after E0 until E10.
- Latency from start to load: WIDTH+1 edges to `load_en` assertion.
- `Dout` is stable throughout the `load_en`-high cycle and until the next good frame's PARITY edge.

## Test plan
- Reset: hold `RST`=1 for 3 cycles with random `start`/`sin` -> `Dout`=8'h00 and `load_en`=`parity_err`=`busy`=0 throughout.
- Good frame: `start`, then `sin` = 1,0,1,0,1,1,1,1 and parity 1 (6 ones, odd) -> `busy` high for 10 cycles, `load_en` high for exactly one cycle at E9–E10, `Dout`=8'hAF, `parity_err`=0.
- Bad parity: `start`, data 8'hFA (6 ones), parity 0 -> `parity_err` pulses once at E9–E10, `load_en`=0, `Dout` stays 8'hAF.
- Ignored start: pulse `start`=1 at E3 and E9 of a frame carrying 8'h83 with parity 0 -> exactly one frame processed, `load_en` once, `Dout`=8'h83, no extra frame after E10.
- Reset mid-frame: assert `RST` asynchronously between E4 and E5 of a frame -> outputs are reset immediately with no pulse. After release, frame 8'hF5 with parity 1 -> `Dout`=8'hF5, `load_en` pulses.
- Back-to-back with `PARITY_ODD`=0 instance: frames 8'h01/parity 1, then `start` at E11, 8'h00/parity 0 -> two `load_en` pulses 11 cycles apart, with `Dout` 8'h01 then 8'h00.
